// File: rtl/pma_tx_pkg.sv
// -----------------------------------------------------------------------------
// pma_tx_pkg
// Shared types and defaults for the 100BASE-TX transmit PMA sequencer.
//   pma_tx_state_t       : sequencer state, also exported on tx_state
//   GROUP_WIDTH_DEFAULT  : bits per 4B/5B code-group
//   IDLE_CODE_DEFAULT    : code-group sent whenever the PCS has nothing valid
//   is_sending()         : true in the states that drive bits onto the line
// -----------------------------------------------------------------------------
package pma_tx_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    QUIET    = 2'd1,
    IDLE     = 2'd2,
    DATA     = 2'd3
  } pma_tx_state_t;

  localparam int         GROUP_WIDTH_DEFAULT = 5;
  localparam logic [4:0] IDLE_CODE_DEFAULT   = 5'b11111;

  function automatic logic is_sending(input pma_tx_state_t s);
    return (s == IDLE) || (s == DATA);
  endfunction

endpackage

// File: rtl/pma_tx_sequencer_if.sv
// -----------------------------------------------------------------------------
// pma_tx_sequencer_if
// Code-group handshake between the PCS 4B/5B encoder and the PMA sequencer.
//   code_group : 5-bit code-group, MSB goes on the line first
//   code_valid : code_group holds a group to send
//   code_ready : sequencer takes code_group this cycle
// Modports: master = PCS side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface pma_tx_sequencer_if
  import pma_tx_pkg::*;
#(
  parameter int GROUP_WIDTH = GROUP_WIDTH_DEFAULT
) ();

  logic [GROUP_WIDTH-1:0] code_group;
  logic                   code_valid;
  logic                   code_ready;

  modport master (
    output code_group,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code_group,
    input  code_valid,
    output code_ready
  );

endinterface

// File: rtl/pma_tx_serializer.sv
// -----------------------------------------------------------------------------
// pma_tx_serializer
// Parallel-load, shift-left register with a bit counter. The register MSB is
// the serial output, so the line bit comes straight from a flop.
//   clock, reset : bit clock, asynchronous active-low reset
//   load         : take load_data, restart the bit counter
//   load_data    : group to send, MSB first
//   clear        : empty the register (line goes to 0) and restart the counter
//   shift        : advance one bit
//   msb          : current serial bit
//   boundary     : last bit of the current group is on the line
// -----------------------------------------------------------------------------
module pma_tx_serializer
  import pma_tx_pkg::*;
#(
  parameter int GROUP_WIDTH = GROUP_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [GROUP_WIDTH-1:0] load_data,
  input  logic                   clear,
  input  logic                   shift,
  output logic                   msb,
  output logic                   boundary
);

  localparam int CNT_W = (GROUP_WIDTH > 1) ? $clog2(GROUP_WIDTH) : 1;

  logic [GROUP_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]       bit_cnt;

  assign boundary = (bit_cnt == CNT_W'(GROUP_WIDTH - 1));
  assign msb      = shift_reg[GROUP_WIDTH-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_cnt   <= '0;
    end else if (shift) begin
      // Zero fill: once a group has fully drained the line sits at 0.
      shift_reg <= shift_reg << 1;
      bit_cnt   <= boundary ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pma_tx_sequencer.sv
// -----------------------------------------------------------------------------
// pma_tx_sequencer
// Transmit-side PMA controller for 100BASE-TX. Serializes PCS code-groups onto
// the NRZ input of the MLT-3 encoder, fills gaps with IDLE groups, and keeps
// the encoder in reset (line quiet) while disabled and during bring-up.
//   clock            : 125 MHz bit clock, one NRZ bit per cycle
//   reset            : asynchronous, active-low
//   tx_enable        : transmit enable from management / auto-negotiation
//   pcs              : code-group handshake (slave side)
//   NRZ              : serial bit to the MLT-3 encoder (flop output)
//   encoder_reset    : active-high reset to the MLT-3 encoder
//   tx_state         : current sequencer state
//   data_group_count : PCS groups accepted, wraps silently
// -----------------------------------------------------------------------------
module pma_tx_sequencer
  import pma_tx_pkg::*;
#(
  parameter int                     GROUP_WIDTH  = GROUP_WIDTH_DEFAULT,
  parameter int                     QUIET_CYCLES = 16,
  parameter logic [GROUP_WIDTH-1:0] IDLE_CODE    = IDLE_CODE_DEFAULT,
  parameter int                     COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tx_enable,
  pma_tx_sequencer_if.slave      pcs,
  output logic                   NRZ,
  output logic                   encoder_reset,
  output pma_tx_state_t          tx_state,
  output logic [COUNT_WIDTH-1:0] data_group_count
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);

  pma_tx_state_t          state;
  logic [QW-1:0]          quiet_cnt;
  logic                   sending;
  logic                   boundary;
  logic                   quiet_done;
  logic                   ser_load;
  logic                   ser_clear;
  logic [GROUP_WIDTH-1:0] ser_data;

  assign sending    = is_sending(state);
  assign quiet_done = (quiet_cnt == QW'(QUIET_CYCLES - 1));

  // Ready only on the last bit of a group; a falling tx_enable on that same
  // cycle wins, so no transfer can happen while shutting down.
  assign pcs.code_ready = sending && boundary && tx_enable;

  assign tx_state = state;

  // Serializer control: what (if anything) replaces the current group.
  always_comb begin
    ser_load  = 1'b0;
    ser_clear = 1'b0;
    ser_data  = IDLE_CODE;
    case (state)
      QUIET: begin
        if (tx_enable && quiet_done) ser_load = 1'b1;
      end
      IDLE, DATA: begin
        if (boundary) begin
          if (!tx_enable) begin
            ser_clear = 1'b1;
          end else begin
            ser_load = 1'b1;
            if (pcs.code_valid) ser_data = pcs.code_group;
          end
        end
      end
      default: ;
    endcase
  end

  pma_tx_serializer #(
    .GROUP_WIDTH (GROUP_WIDTH)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (ser_load),
    .load_data (ser_data),
    .clear     (ser_clear),
    .shift     (sending),
    .msb       (NRZ),
    .boundary  (boundary)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= DISABLED;
      quiet_cnt        <= '0;
      encoder_reset    <= 1'b1;
      data_group_count <= '0;
    end else begin
      case (state)
        DISABLED: begin
          if (tx_enable) begin
            state     <= QUIET;
            quiet_cnt <= '0;
          end
        end
        QUIET: begin
          if (!tx_enable) begin
            state <= DISABLED;
          end else if (quiet_done) begin
            // Encoder leaves reset together with the first IDLE bit.
            state         <= IDLE;
            encoder_reset <= 1'b0;
          end else begin
            quiet_cnt <= quiet_cnt + QW'(1);
          end
        end
        IDLE, DATA: begin
          if (boundary) begin
            if (!tx_enable) begin
              state         <= DISABLED;
              encoder_reset <= 1'b1;
            end else if (pcs.code_valid) begin
              state            <= DATA;
              data_group_count <= data_group_count + COUNT_WIDTH'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state         <= DISABLED;
          encoder_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pma_tx_sequencer.sv
module tb_pma_tx_sequencer;
  import pma_tx_pkg::*;

  localparam int GW = 5;
  localparam int QC = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tx_enable = 1'b0;
  logic          NRZ;
  logic          encoder_reset;
  pma_tx_state_t tx_state;
  logic [CW-1:0] data_group_count;

  int vectors = 0;
  int miscompares = 0;

  pma_tx_sequencer_if #(.GROUP_WIDTH(GW)) pcs_if ();

  pma_tx_sequencer #(
    .GROUP_WIDTH  (GW),
    .QUIET_CYCLES (QC),
    .IDLE_CODE    (5'b11111),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .tx_enable        (tx_enable),
    .pcs              (pcs_if),
    .NRZ              (NRZ),
    .encoder_reset    (encoder_reset),
    .tx_state         (tx_state),
    .data_group_count (data_group_count)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    pcs_if.code_valid = 1'b0;
    pcs_if.code_group = '0;
    tx_enable = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(negedge clock);
    vectors++; if (NRZ !== 1'b0) begin miscompares++; $display("FAIL reset nrz: got %b want 0", NRZ); end
    vectors++; if (pcs_if.code_ready !== 1'b0) begin miscompares++; $display("FAIL reset code_ready: got %b want 0", pcs_if.code_ready); end
    vectors++; if (encoder_reset !== 1'b1) begin miscompares++; $display("FAIL reset encoder_reset: got %b want 1", encoder_reset); end
    vectors++; if (tx_state !== DISABLED) begin miscompares++; $display("FAIL reset tx_state: got %0d want %0d", tx_state, DISABLED); end
    vectors++; if (data_group_count !== 3'd0) begin miscompares++; $display("FAIL reset count: got %0d want 0", data_group_count); end
  endtask

  // Release reset with tx_enable high: 4 QUIET cycles, then IDLE ones.
  // Ends on the negedge of the first IDLE group's boundary cycle.
  task automatic test_bringup();
    pma_tx_state_t exp_st;
    reset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      exp_st = (i <= 4) ? QUIET : IDLE;
      vectors++; if (tx_state !== exp_st) begin miscompares++; $display("FAIL bringup state[%0d]: got %0d want %0d", i, tx_state, exp_st); end
      vectors++; if (encoder_reset !== (i <= 4)) begin miscompares++; $display("FAIL bringup encoder_reset[%0d]: got %b want %b", i, encoder_reset, (i <= 4)); end
      vectors++; if (NRZ !== (i > 4)) begin miscompares++; $display("FAIL bringup nrz[%0d]: got %b want %b", i, NRZ, (i > 4)); end
      vectors++; if (pcs_if.code_ready !== (i == 9)) begin miscompares++; $display("FAIL bringup code_ready[%0d]: got %b want %b", i, pcs_if.code_ready, (i == 9)); end
    end
  endtask

  // Single data group 10101; valid stays high off-boundary (no extra transfer).
  task automatic test_data();
    logic [4:0] g;
    g = 5'b10101;
    pcs_if.code_group = g;
    pcs_if.code_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clock);
      vectors++; if (NRZ !== g[4-b]) begin miscompares++; $display("FAIL data nrz[%0d]: got %b want %b", b, NRZ, g[4-b]); end
      vectors++; if (tx_state !== DATA) begin miscompares++; $display("FAIL data state[%0d]: got %0d want %0d", b, tx_state, DATA); end
      vectors++; if (data_group_count !== 3'd1) begin miscompares++; $display("FAIL data count[%0d]: got %0d want 1", b, data_group_count); end
      vectors++; if (pcs_if.code_ready !== (b == 4)) begin miscompares++; $display("FAIL data code_ready[%0d]: got %b want %b", b, pcs_if.code_ready, (b == 4)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] stream;
    stream = 10'b00011_10110;
    pcs_if.code_group = 5'b00011;
    pcs_if.code_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      vectors++; if (NRZ !== stream[9-i]) begin miscompares++; $display("FAIL b2b nrz[%0d]: got %b want %b", i, NRZ, stream[9-i]); end
      vectors++; if (tx_state !== DATA) begin miscompares++; $display("FAIL b2b state[%0d]: got %0d want %0d", i, tx_state, DATA); end
      vectors++; if (data_group_count !== ((i < 5) ? 3'd2 : 3'd3)) begin miscompares++; $display("FAIL b2b count[%0d]: got %0d want %0d", i, data_group_count, (i < 5) ? 2 : 3); end
      vectors++; if (pcs_if.code_ready !== (i == 4 || i == 9)) begin miscompares++; $display("FAIL b2b code_ready[%0d]: got %b want %b", i, pcs_if.code_ready, (i == 4 || i == 9)); end
      if (i == 4) pcs_if.code_group = 5'b10110;
    end
  endtask

  task automatic test_idle_fill();
    pcs_if.code_valid = 1'b0;
    pcs_if.code_group = 5'b00000;
    for (int b = 0; b < 5; b++) begin
      @(negedge clock);
      vectors++; if (NRZ !== 1'b1) begin miscompares++; $display("FAIL idle nrz[%0d]: got %b want 1", b, NRZ); end
      vectors++; if (tx_state !== IDLE) begin miscompares++; $display("FAIL idle state[%0d]: got %0d want %0d", b, tx_state, IDLE); end
      vectors++; if (data_group_count !== 3'd3) begin miscompares++; $display("FAIL idle count[%0d]: got %0d want 3", b, data_group_count); end
      vectors++; if (pcs_if.code_ready !== (b == 4)) begin miscompares++; $display("FAIL idle code_ready[%0d]: got %b want %b", b, pcs_if.code_ready, (b == 4)); end
    end
  endtask

  // Five more groups take the 3-bit counter 3 -> 4,5,6,7,0.
  task automatic test_count_wrap();
    logic [4:0] grp [5];
    logic [2:0] exp_cnt;
    grp[0] = 5'b00000; grp[1] = 5'b11001; grp[2] = 5'b01010;
    grp[3] = 5'b10011; grp[4] = 5'b00111;
    pcs_if.code_group = grp[0];
    pcs_if.code_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      exp_cnt = 3'((4 + i / 5) % 8);
      vectors++; if (NRZ !== grp[i/5][4 - i%5]) begin miscompares++; $display("FAIL wrap nrz[%0d]: got %b want %b", i, NRZ, grp[i/5][4 - i%5]); end
      vectors++; if (data_group_count !== exp_cnt) begin miscompares++; $display("FAIL wrap count[%0d]: got %0d want %0d", i, data_group_count, exp_cnt); end
      if (i % 5 == 4 && i / 5 < 4) pcs_if.code_group = grp[i/5 + 1];
    end
  endtask

  // tx_enable drops at bit 2; the group finishes, and the valid group offered
  // on the boundary must not be taken.
  task automatic test_disable_mid();
    logic [4:0] g;
    g = 5'b01101;
    pcs_if.code_group = g;
    pcs_if.code_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (i < 5) begin
        vectors++; if (NRZ !== g[4-i]) begin miscompares++; $display("FAIL disable nrz[%0d]: got %b want %b", i, NRZ, g[4-i]); end
        vectors++; if (tx_state !== DATA) begin miscompares++; $display("FAIL disable state[%0d]: got %0d want %0d", i, tx_state, DATA); end
      end else begin
        vectors++; if (NRZ !== 1'b0) begin miscompares++; $display("FAIL disable nrz[%0d]: got %b want 0", i, NRZ); end
        vectors++; if (tx_state !== DISABLED) begin miscompares++; $display("FAIL disable state[%0d]: got %0d want %0d", i, tx_state, DISABLED); end
        vectors++; if (encoder_reset !== 1'b1) begin miscompares++; $display("FAIL disable encoder_reset[%0d]: got %b want 1", i, encoder_reset); end
      end
      vectors++; if (pcs_if.code_ready !== 1'b0) begin miscompares++; $display("FAIL disable code_ready[%0d]: got %b want 0", i, pcs_if.code_ready); end
      vectors++; if (data_group_count !== 3'd1) begin miscompares++; $display("FAIL disable count[%0d]: got %0d want 1", i, data_group_count); end
      if (i == 2) tx_enable = 1'b0;
    end
  endtask

  // Re-enable, then assert reset at bit 2 of an IDLE group: aborts at once.
  task automatic test_reset_mid();
    pcs_if.code_valid = 1'b0;
    tx_enable = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock);
      vectors++; if (tx_state !== ((i <= 4) ? QUIET : IDLE)) begin miscompares++; $display("FAIL reenable state[%0d]: got %0d want %0d", i, tx_state, (i <= 4) ? QUIET : IDLE); end
      vectors++; if (NRZ !== (i > 4)) begin miscompares++; $display("FAIL reenable nrz[%0d]: got %b want %b", i, NRZ, (i > 4)); end
    end
    reset = 1'b0;
    #1;
    vectors++; if (tx_state !== DISABLED) begin miscompares++; $display("FAIL rstmid state: got %0d want %0d", tx_state, DISABLED); end
    vectors++; if (NRZ !== 1'b0) begin miscompares++; $display("FAIL rstmid nrz: got %b want 0", NRZ); end
    vectors++; if (encoder_reset !== 1'b1) begin miscompares++; $display("FAIL rstmid encoder_reset: got %b want 1", encoder_reset); end
    vectors++; if (data_group_count !== 3'd0) begin miscompares++; $display("FAIL rstmid count: got %0d want 0", data_group_count); end
    vectors++; if (pcs_if.code_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid code_ready: got %b want 0", pcs_if.code_ready); end
  endtask

  // Dropping tx_enable during QUIET returns to DISABLED on the next edge.
  task automatic test_quiet_abort();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors++; if (tx_state !== QUIET) begin miscompares++; $display("FAIL qabort state1: got %0d want %0d", tx_state, QUIET); end
    @(negedge clock);
    vectors++; if (tx_state !== QUIET) begin miscompares++; $display("FAIL qabort state2: got %0d want %0d", tx_state, QUIET); end
    tx_enable = 1'b0;
    @(negedge clock);
    vectors++; if (tx_state !== DISABLED) begin miscompares++; $display("FAIL qabort state3: got %0d want %0d", tx_state, DISABLED); end
    vectors++; if (encoder_reset !== 1'b1) begin miscompares++; $display("FAIL qabort encoder_reset: got %b want 1", encoder_reset); end
    vectors++; if (NRZ !== 1'b0) begin miscompares++; $display("FAIL qabort nrz: got %b want 0", NRZ); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_data();
    test_back_to_back();
    test_idle_fill();
    test_count_wrap();
    test_disable_mid();
    test_reset_mid();
    test_quiet_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
